// File: rtl/ps2_cmd_arbiter_pkg.sv
// rtl/ps2_cmd_arbiter_pkg.sv - PS/2 protocol bytes and arbiter FSM state encoding
package ps2_cmd_arbiter_pkg;

  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;
  localparam logic [7:0] PS2_ERROR      = 8'hFC;
  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RATE   = 8'hF3;
  localparam logic [7:0] PS2_CMD_GET_ID = 8'hF2;

  // Encoding is visible on debug[2:0]; IDLE must stay 0 so reset reads as all-zero.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_TX  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_RESP     = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic logic is_timed_state(input state_e s);
    return (s == ST_WAIT_TX) || (s == ST_WAIT_ACK) || (s == ST_RESP);
  endfunction

endpackage

// File: rtl/ps2_cmd_arbiter_if.sv
// rtl/ps2_cmd_arbiter_if.sv - requester, PS/2 TX/RX and stream signals of the command arbiter
interface ps2_cmd_arbiter_if;

  logic       req0;
  logic       req1;
  logic [7:0] cmd0;
  logic [7:0] cmd1;
  logic [1:0] len0;
  logic [1:0] len1;
  logic [1:0] gnt;
  logic       done;
  logic       err;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  logic       busy;
  logic       read;
  logic [7:0] rx_data;
  logic       write;
  logic [7:0] tx_data;

  logic       strm_valid;
  logic [7:0] strm_data;
  logic [7:0] debug;

  modport slave (
    input  req0, req1, cmd0, cmd1, len0, len1, busy, read, rx_data,
    output gnt, done, err, rsp_valid, rsp_data, write, tx_data,
           strm_valid, strm_data, debug
  );

  modport master (
    output req0, req1, cmd0, cmd1, len0, len1, busy, read, rx_data,
    input  gnt, done, err, rsp_valid, rsp_data, write, tx_data,
           strm_valid, strm_data, debug
  );

endinterface

// File: rtl/ps2_timeout.sv
// rtl/ps2_timeout.sv - wait-state timeout counter with clear and enable
module ps2_timeout #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int TW             = 22
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt;

  // Clear acts in the same cycle, so the first cycle of a state counts as cycle 0.
  assign w_cnt     = i_clr ? '0 : r_cnt;
  assign o_expired = i_en && (w_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// rtl/ps2_cmd_arbiter.sv - two-requester PS/2 mouse command arbiter with ACK/RESEND/timeout handling
module ps2_cmd_arbiter
  import ps2_cmd_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int MAX_RETRY      = 3,
  parameter int TW             = 22
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ps2_cmd_arbiter_if.slave  bus
);

  state_e     r_state;
  state_e     r_state_q;
  logic [1:0] r_gnt;
  logic [7:0] r_cmd;
  logic [1:0] r_len;
  logic [1:0] r_retry;
  logic       r_busy_seen;
  logic       r_write;
  logic [7:0] r_tx_data;
  logic       r_done;
  logic       r_err;
  logic       r_err_sticky;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_strm_valid;
  logic [7:0] r_strm_data;

  logic       w_tmo_clr;
  logic       w_tmo_en;
  logic       w_expired;
  logic       w_can_retry;

  // r_state_q lags r_state by one cycle, so a mismatch marks the first cycle in a state.
  assign w_tmo_clr   = bus.read || (r_state != r_state_q);
  assign w_tmo_en    = is_timed_state(r_state);
  assign w_can_retry = (int'(r_retry) < MAX_RETRY);

  ps2_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_state_q    <= ST_IDLE;
      r_gnt        <= 2'b00;
      r_cmd        <= 8'h00;
      r_len        <= 2'd0;
      r_retry      <= 2'd0;
      r_busy_seen  <= 1'b0;
      r_write      <= 1'b0;
      r_tx_data    <= 8'h00;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 8'h00;
      r_strm_valid <= 1'b0;
      r_strm_data  <= 8'h00;
    end else begin
      r_state_q    <= r_state;
      r_write      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_strm_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.read) begin
            r_strm_valid <= 1'b1;
            r_strm_data  <= bus.rx_data;
          end
          if (bus.req0) begin
            r_gnt       <= 2'b01;
            r_cmd       <= bus.cmd0;
            r_len       <= bus.len0;
            r_retry     <= 2'd0;
            r_busy_seen <= 1'b0;
            r_write     <= 1'b1;
            r_tx_data   <= bus.cmd0;
            r_state     <= ST_SEND;
          end else if (bus.req1) begin
            r_gnt       <= 2'b10;
            r_cmd       <= bus.cmd1;
            r_len       <= bus.len1;
            r_retry     <= 2'd0;
            r_busy_seen <= 1'b0;
            r_write     <= 1'b1;
            r_tx_data   <= bus.cmd1;
            r_state     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (bus.read) begin
            r_strm_valid <= 1'b1;
            r_strm_data  <= bus.rx_data;
          end
          r_state <= ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          if (bus.read) begin
            r_strm_valid <= 1'b1;
            r_strm_data  <= bus.rx_data;
          end
          // Only a fall after an observed rise means the byte left the transmitter.
          if (w_expired) begin
            r_done       <= 1'b1;
            r_err        <= 1'b1;
            r_err_sticky <= 1'b1;
            r_state      <= ST_DONE;
          end else if (r_busy_seen && !bus.busy) begin
            r_state <= ST_WAIT_ACK;
          end else if (bus.busy) begin
            r_busy_seen <= 1'b1;
          end
        end

        ST_WAIT_ACK: begin
          if (bus.read) begin
            case (bus.rx_data)
              PS2_ACK: begin
                if (r_len != 2'd0) begin
                  r_state <= ST_RESP;
                end else begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
                end
              end
              PS2_RESEND: begin
                if (w_can_retry) begin
                  r_retry     <= r_retry + 2'd1;
                  r_busy_seen <= 1'b0;
                  r_write     <= 1'b1;
                  r_tx_data   <= r_cmd;
                  r_state     <= ST_SEND;
                end else begin
                  r_done       <= 1'b1;
                  r_err        <= 1'b1;
                  r_err_sticky <= 1'b1;
                  r_state      <= ST_DONE;
                end
              end
              PS2_ERROR: begin
                r_done       <= 1'b1;
                r_err        <= 1'b1;
                r_err_sticky <= 1'b1;
                r_state      <= ST_DONE;
              end
              default: begin
                r_strm_valid <= 1'b1;
                r_strm_data  <= bus.rx_data;
              end
            endcase
          end else if (w_expired) begin
            r_done       <= 1'b1;
            r_err        <= 1'b1;
            r_err_sticky <= 1'b1;
            r_state      <= ST_DONE;
          end
        end

        ST_RESP: begin
          if (bus.read) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.rx_data;
            r_len       <= r_len - 2'd1;
            if (r_len == 2'd1) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else if (w_expired) begin
            r_done       <= 1'b1;
            r_err        <= 1'b1;
            r_err_sticky <= 1'b1;
            r_state      <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (bus.read) begin
            r_strm_valid <= 1'b1;
            r_strm_data  <= bus.rx_data;
          end
          r_gnt   <= 2'b00;
          r_state <= ST_IDLE;
        end

        default: begin
          r_gnt   <= 2'b00;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.write      = r_write;
  assign bus.tx_data    = r_tx_data;
  assign bus.strm_valid = r_strm_valid;
  assign bus.strm_data  = r_strm_data;
  assign bus.debug      = {r_err_sticky, r_gnt, r_retry, r_state};

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// tb/tb_ps2_cmd_arbiter.sv - directed self-checking bench for ps2_cmd_arbiter
module tb_ps2_cmd_arbiter;
  import ps2_cmd_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cnt;

  ps2_cmd_arbiter_if bus();

  ps2_cmd_arbiter #(
    .TIMEOUT_CYCLES (100),
    .MAX_RETRY      (3),
    .TW             (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.read    = 1'b1;
    bus.rx_data = b;
    tick();
    bus.read    = 1'b0;
  endtask

  task automatic busy_pulse();
    bus.busy = 1'b1;
    tick();
    tick();
    bus.busy = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.cmd0 = 8'h00; bus.cmd1 = 8'h00;
    bus.len0 = 2'd0;  bus.len1 = 2'd0;
    bus.busy = 1'b0;  bus.read = 1'b0; bus.rx_data = 8'h00;
    tick(); tick();
    check("rst_gnt",   32'(bus.gnt), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_write", 32'(bus.write), 0);
    check("rst_tx",    32'(bus.tx_data), 0);
    check("rst_debug", 32'(bus.debug), 0);
    rst_n = 1'b1;
    tick();

    // 1: reset command with two response bytes
    bus.req0 = 1'b1; bus.cmd0 = PS2_CMD_RESET; bus.len0 = 2'd2;
    tick();
    check("t1_write", 32'(bus.write), 1);
    check("t1_tx",    32'(bus.tx_data), 32'hFF);
    check("t1_gnt",   32'(bus.gnt), 32'h1);
    tick();
    check("t1_write_once", 32'(bus.write), 0);
    tick();
    check("t1_wait_tx_hold", 32'(bus.debug[2:0]), 2);
    busy_pulse();
    check("t1_wait_ack", 32'(bus.debug[2:0]), 3);
    rx_byte(PS2_ACK);
    check("t1_resp_state", 32'(bus.debug[2:0]), 4);
    rx_byte(PS2_BAT_OK);
    check("t1_rsp0_v", 32'(bus.rsp_valid), 1);
    check("t1_rsp0_d", 32'(bus.rsp_data), 32'hAA);
    check("t1_done_early", 32'(bus.done), 0);
    rx_byte(8'h00);
    check("t1_rsp1_v", 32'(bus.rsp_valid), 1);
    check("t1_rsp1_d", 32'(bus.rsp_data), 32'h00);
    check("t1_done",   32'(bus.done), 1);
    check("t1_err",    32'(bus.err), 0);
    bus.req0 = 1'b0;
    tick();
    check("t1_idle_gnt", 32'(bus.gnt), 0);
    check("t1_idle_dbg", 32'(bus.debug), 0);

    // 2: simultaneous requests, requester 0 wins, then 1 with no overlap
    bus.req0 = 1'b1; bus.cmd0 = PS2_CMD_ENABLE; bus.len0 = 2'd0;
    bus.req1 = 1'b1; bus.cmd1 = PS2_CMD_RATE;   bus.len1 = 2'd0;
    tick();
    check("t2_gnt0", 32'(bus.gnt), 32'h1);
    check("t2_tx0",  32'(bus.tx_data), 32'hF4);
    busy_pulse();
    rx_byte(PS2_ACK);
    check("t2_done0", 32'(bus.done), 1);
    check("t2_gnt0_done", 32'(bus.gnt), 32'h1);
    bus.req0 = 1'b0;
    tick();
    check("t2_gap_gnt", 32'(bus.gnt), 0);
    tick();
    check("t2_gnt1",   32'(bus.gnt), 32'h2);
    check("t2_write1", 32'(bus.write), 1);
    check("t2_tx1",    32'(bus.tx_data), 32'hF3);
    busy_pulse();
    rx_byte(PS2_ACK);
    check("t2_done1", 32'(bus.done), 1);
    bus.req1 = 1'b0;
    tick();

    // 3: two resends then success
    bus.req1 = 1'b1; bus.cmd1 = PS2_CMD_GET_ID; bus.len1 = 2'd1;
    tick();
    check("t3_write0", 32'(bus.write), 1);
    check("t3_tx",     32'(bus.tx_data), 32'hF2);
    busy_pulse();
    rx_byte(PS2_RESEND);
    check("t3_write1", 32'(bus.write), 1);
    check("t3_retry1", 32'(bus.debug[4:3]), 1);
    busy_pulse();
    rx_byte(PS2_RESEND);
    check("t3_write2", 32'(bus.write), 1);
    check("t3_tx2",    32'(bus.tx_data), 32'hF2);
    busy_pulse();
    rx_byte(PS2_ACK);
    check("t3_no_write", 32'(bus.write), 0);
    rx_byte(8'h03);
    check("t3_rsp_v", 32'(bus.rsp_valid), 1);
    check("t3_rsp_d", 32'(bus.rsp_data), 32'h03);
    check("t3_done",  32'(bus.done), 1);
    check("t3_err",   32'(bus.err), 0);
    check("t3_retry", 32'(bus.debug[4:3]), 2);
    check("t3_gnt",   32'(bus.gnt), 32'h2);
    bus.req1 = 1'b0;
    tick();

    // 4: retries exhausted
    bus.req0 = 1'b1; bus.cmd0 = PS2_CMD_ENABLE; bus.len0 = 2'd0;
    tick();
    check("t4_write_first", 32'(bus.write), 1);
    for (int i = 0; i < 4; i++) begin
      busy_pulse();
      rx_byte(PS2_RESEND);
      if (i < 3) check($sformatf("t4_write_retry%0d", i + 1), 32'(bus.write), 1);
    end
    check("t4_no_write", 32'(bus.write), 0);
    check("t4_done",     32'(bus.done), 1);
    check("t4_err",      32'(bus.err), 1);
    check("t4_sticky",   32'(bus.debug[7]), 1);
    check("t4_retry",    32'(bus.debug[4:3]), 3);
    bus.req0 = 1'b0;
    tick();

    // 5a: busy never falls
    bus.req1 = 1'b1; bus.cmd1 = PS2_CMD_ENABLE; bus.len1 = 2'd0;
    tick();
    bus.busy = 1'b1;
    tick();
    check("t5a_state", 32'(bus.debug[2:0]), 2);
    cnt = 0;
    while (!bus.done && cnt < 300) begin
      tick();
      cnt++;
    end
    check("t5a_latency", 32'(cnt), 100);
    check("t5a_err",     32'(bus.err), 1);
    bus.busy = 1'b0;
    bus.req1 = 1'b0;
    tick();

    // 5b: transmitted, no reply
    bus.req1 = 1'b1;
    tick();
    busy_pulse();
    check("t5b_state", 32'(bus.debug[2:0]), 3);
    cnt = 0;
    while (!bus.done && cnt < 300) begin
      tick();
      cnt++;
    end
    check("t5b_latency", 32'(cnt), 100);
    check("t5b_err",     32'(bus.err), 1);
    bus.req1 = 1'b0;
    tick();

    // 6: unsolicited bytes, then async reset mid-transaction
    rx_byte(8'h08);
    check("t6_strm0_v", 32'(bus.strm_valid), 1);
    check("t6_strm0_d", 32'(bus.strm_data), 32'h08);
    rx_byte(8'h01);
    check("t6_strm1_d", 32'(bus.strm_data), 32'h01);
    rx_byte(8'h02);
    check("t6_strm2_v", 32'(bus.strm_valid), 1);
    check("t6_strm2_d", 32'(bus.strm_data), 32'h02);
    tick();
    check("t6_strm_end", 32'(bus.strm_valid), 0);
    bus.req0 = 1'b1; bus.cmd0 = PS2_CMD_ENABLE; bus.len0 = 2'd0;
    tick();
    busy_pulse();
    tick();
    check("t6_wait_ack", 32'(bus.debug[2:0]), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt",   32'(bus.gnt), 0);
    check("t6_rst_tx",    32'(bus.tx_data), 0);
    check("t6_rst_strm",  32'(bus.strm_data), 0);
    check("t6_rst_debug", 32'(bus.debug), 0);
    check("t6_rst_flags", 32'({bus.done, bus.err, bus.write, bus.rsp_valid, bus.strm_valid}), 0);
    bus.req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_idle", 32'(bus.debug), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
